// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter control slice: arbiter state encoding,
// counter start value and default sizing.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int COUNT_RESET_VAL   = 1;
  localparam int DEFAULT_N_REQ     = 4;
  localparam int DEFAULT_CNT_WIDTH = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request strictly after
// last_winner, ascending with wrap-around.
module rr_pick
  import counter_ctrl_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic found;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    winner  = '0;
    found   = 1'b0;
    any_req = |req;
    for (int off = 1; off <= N_REQ; off++) begin
      int idx;
      idx = (int'(last_winner) + off) % N_REQ;
      if (!found && req[idx]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/increase_arbiter.sv
// Round-robin arbiter sharing one counter's Increase input among N_REQ
// requesters; also keeps a shadow of the counter value and flags wrap-around.
module increase_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter int N_REQ     = DEFAULT_N_REQ,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [N_REQ-1:0]     Req,
  output logic [N_REQ-1:0]     Grant,
  output logic                 Increase,
  output logic                 Busy,
  output logic [CNT_WIDTH-1:0] Count,
  output logic                 Wrap
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state, next_state;
  logic [IDX_W-1:0] last_winner;
  logic [IDX_W-1:0] pick;
  logic             any_req;
  logic             load_grant;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req         (Req),
    .last_winner (last_winner),
    .winner      (pick),
    .any_req     (any_req)
  );

  // load_grant marks every entry into GRANT; the grant, pulse and count are
  // all registered on that edge so they appear together for exactly one cycle.
  always_comb begin
    next_state = state;
    load_grant = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          next_state = GRANT;
          load_grant = 1'b1;
        end
      end
      GRANT: next_state = RELEASE;
      RELEASE: begin
        if (!Req[last_winner]) begin
          if (any_req) begin
            next_state = GRANT;
            load_grant = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      last_winner <= IDX_W'(N_REQ - 1);
      Grant       <= '0;
      Increase    <= 1'b0;
      Count       <= CNT_WIDTH'(COUNT_RESET_VAL);
      Wrap        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so the default clears below and the conditional
      // loads resolve as last-assignment-wins without ordering races.
      state    <= next_state;
      Grant    <= '0;
      Increase <= 1'b0;
      Wrap     <= 1'b0;
      if (load_grant) begin
        last_winner <= pick;
        Grant       <= N_REQ'(1) << pick;
        Increase    <= 1'b1;
        Count       <= Count + CNT_WIDTH'(1);
        Wrap        <= &Count;
      end
    end
  end

  assign Busy = (state != IDLE);

endmodule
